// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read; contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU memory port responder: req/ready handshake with WAIT programmable wait states.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              wr,
    input  logic [WORD_W-1:0] Address,
    input  logic [WORD_W-1:0] Datain,
    output logic [WORD_W-1:0] Dataout,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'((WAIT > 0) ? WAIT - 1 : 0);

    mem_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  rd_hit_q, rd_hit_d;
    logic [WORD_W-1:0]     dataout_q, dataout_d;
    logic [WORD_W-1:0]     addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [WORD_W-1:0]     din_q, din_d;

    logic                  accept;
    logic                  enter_resp;
    logic                  misaligned;
    logic                  ram_en;
    logic                  ram_we;
    logic [WORD_W-1:0]     ram_rdata;
    logic                  unused_addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            mem_pkg::IDLE, mem_pkg::RESP: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_d    = mem_pkg::RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = mem_pkg::WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = mem_pkg::IDLE;
                end
            end
            mem_pkg::WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = mem_pkg::RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = mem_pkg::IDLE;
        endcase
    end

    // With WAIT=0 the access happens on the accepting edge, so the live
    // inputs stand in for the latch that is being loaded on that same edge.
    always_comb begin
        addr_d = accept ? Address : addr_q;
        wr_d   = accept ? wr      : wr_q;
        din_d  = accept ? Datain  : din_q;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (addr_d[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign unused_addr = ^{addr_d[WORD_W-1:IDX_W+2], addr_d[1:0]};

    always_comb begin
        ram_en    = enter_resp && !misaligned;
        ram_we    = ram_en && wr_d;
        ready_d   = enter_resp;
        busy_d    = (state_d != mem_pkg::IDLE);
        err_d     = enter_resp && misaligned;
        rd_hit_d  = ram_en && !wr_d;
        dataout_d = rd_hit_q ? ram_rdata : dataout_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= mem_pkg::IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_hit_q  <= 1'b0;
            dataout_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            rd_hit_q  <= rd_hit_d;
            dataout_q <= dataout_d;
        end
    end

    always_ff @(posedge Clk) begin
        addr_q <= addr_d;
        wr_q   <= wr_d;
        din_q  <= din_d;
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (Clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_d[IDX_W+1:2]),
        .wdata (din_d),
        .rdata (ram_rdata)
    );

    // RAM output is live only in the RESP cycle of a read; the register holds it afterwards.
    assign Dataout = rd_hit_q ? ram_rdata : dataout_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a WAIT=0 and a WAIT=2 instance against a word-array model.
module tb_mem_responder;

    localparam int DEPTH = 256;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        req_s   [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] din_s   [2];
    logic [31:0] dout_s  [2];
    logic        ready_s [2];
    logic        busy_s  [2];
    logic        err_s   [2];

    logic [31:0] mdl   [2][DEPTH];
    logic [31:0] mdout [2];

    bit          bw [32];
    logic [31:0] ba [32];
    logic [31:0] bd [32];

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .req(req_s[0]), .wr(wr_s[0]),
        .Address(addr_s[0]), .Datain(din_s[0]), .Dataout(dout_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .err(err_s[0])
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT(2)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(req_s[1]), .wr(wr_s[1]),
        .Address(addr_s[1]), .Datain(din_s[1]), .Dataout(dout_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .err(err_s[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int waitv(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outcome of one completed transaction, seen in its ready cycle.
    task automatic apply_result(input int s, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input string tag);
        int idx;
        bit mis;
        idx = int'((a >> 2) % DEPTH);
        mis = ALIGN && (a % 4 != 0);
        chk({tag, ":err"}, 32'(err_s[s]), 32'(mis));
        if (!mis) begin
            if (w) mdl[s][idx] = d;
            else   mdout[s]    = mdl[s][idx];
        end
        chk({tag, ":dout"}, dout_s[s], mdout[s]);
    endtask

    task automatic txn(input int s, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        int n;
        @(negedge Clk);
        req_s[s] = 1'b1; wr_s[s] = w; addr_s[s] = a; din_s[s] = d;
        @(negedge Clk);
        req_s[s] = 1'b0; wr_s[s] = 1'($urandom); addr_s[s] = $urandom; din_s[s] = $urandom;
        chk({tag, ":busy"}, 32'(busy_s[s]), 1);
        n = 1;
        while (!ready_s[s] && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, ":lat"}, n, waitv(s) + 1);
        apply_result(s, w, a, d, tag);
        @(negedge Clk);
        chk({tag, ":pulse"}, 32'(ready_s[s]), 0);
        chk({tag, ":idle"}, 32'(busy_s[s]), 0);
        chk({tag, ":hold"}, dout_s[s], mdout[s]);
    endtask

    task automatic drive_b(input int s, input int k);
        req_s[s] = 1'b1; wr_s[s] = bw[k]; addr_s[s] = ba[k]; din_s[s] = bd[k];
    endtask

    // Request held high; the next transaction is presented while the current one waits.
    task automatic b2b(input int s, input int cnt, input string tag);
        @(negedge Clk);
        drive_b(s, 0);
        for (int k = 0; k < cnt; k++) begin
            repeat (waitv(s)) begin
                @(negedge Clk);
                chk({tag, ":wait"}, 32'(ready_s[s]), 0);
            end
            @(negedge Clk);
            chk({tag, ":rdy"}, 32'(ready_s[s]), 1);
            apply_result(s, bw[k], ba[k], bd[k], tag);
            if (k + 1 < cnt) drive_b(s, k + 1);
            else             req_s[s] = 1'b0;
        end
        @(negedge Clk);
        chk({tag, ":end"}, 32'(ready_s[s]), 0);
    endtask

    initial begin
        logic [31:0] v30;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; wr_s[s] = 1'b0; addr_s[s] = '0; din_s[s] = '0;
            mdout[s] = '0;
        end
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        repeat (10) begin
            @(negedge Clk);
            for (int s = 0; s < 2; s++) begin
                chk("rst_dout", dout_s[s], 32'h0);
                chk("rst_ready", 32'(ready_s[s]), 0);
                chk("rst_busy", 32'(busy_s[s]), 0);
                chk("rst_err", 32'(err_s[s]), 0);
            end
        end

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                txn(s, 1'b1, 32'(i * 4), $urandom, "fill");

        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, "w10");
        txn(1, 1'b0, 32'h10, 32'h0, "r10");
        chk("r10_val", dout_s[1], 32'hDEADBEEF);

        bw[0] = 1'b1; ba[0] = 32'h20; bd[0] = 32'h12345678;
        bw[1] = 1'b0; ba[1] = 32'h20; bd[1] = 32'h0;
        b2b(0, 2, "b2b20");
        chk("b2b20_val", dout_s[0], 32'h12345678);

        txn(1, 1'b1, 32'h004, 32'hA5A5A5A5, "alias_w");
        txn(1, 1'b0, 32'h404, 32'h0, "alias_r");
        chk("alias_val", dout_s[1], 32'hA5A5A5A5);

        txn(1, 1'b0, 32'h13, 32'h0, "mis13");
        chk("mis13_err", 32'(err_s[1]), 32'(0));

        for (int i = 0; i < 60; i++)
            txn(1, 1'($urandom), $urandom, $urandom, "rnd1");

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                bw[k] = 1'($urandom);
                ba[k] = (k % 4 == 3) ? ba[k - 1] + 32'(DEPTH * 4) : $urandom;
                bd[k] = $urandom;
            end
            b2b(s, 16, "rndb2b");
        end

        v30 = $urandom;
        txn(1, 1'b1, 32'h30, v30, "pre30");
        @(negedge Clk);
        req_s[1] = 1'b1; wr_s[1] = 1'b1; addr_s[1] = 32'h30; din_s[1] = 32'hFFFFFFFF;
        @(negedge Clk);
        req_s[1] = 1'b0;
        chk("abort_busy", 32'(busy_s[1]), 1);
        #2 Reset = 1'b1;
        #1;
        mdout[0] = '0;
        mdout[1] = '0;
        chk("abort_dout", dout_s[1], 32'h0);
        chk("abort_ready", 32'(ready_s[1]), 0);
        chk("abort_busy0", 32'(busy_s[1]), 0);
        chk("abort_err", 32'(err_s[1]), 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            chk("abort_noready", 32'(ready_s[1]), 0);
        end
        txn(1, 1'b0, 32'h30, 32'h0, "post30");
        chk("post30_val", dout_s[1], v30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data/instruction memory that answers the multicycle CPU's memory port (Address, wr, Datain, Dataout) through a req/ready handshake with programmable wait states. The CPU control FSM holds a request and stalls its state until `ready` pulses, so the core can run against slower backing storage. The block sits between the CPU's IorD address mux and the IR/MDR load paths.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `WAIT`, 2: wait cycles between acceptance and response; range 0..15.
- `Clk  in  1`: single clock, rising edge.
- `Reset  in  1`: asynchronous, active-high reset.
- `req  in  1`: request valid; sampled only in IDLE or RESP.
- `wr  in  1`: 1 = write, 0 = read; qualified by `req`.
- `Address  in  32`: byte address; word index = `Address[log2(DEPTH)+1:2]`.
- `Datain  in  32`: write data; qualified by `req & wr`.
- `Dataout  out  32`: read data; holds its value until the next read completes.
- `ready  out  1`: one-cycle completion pulse.
- `busy  out  1`: high while a transaction is held (WAIT or RESP).
- `err  out  1`: misalignment flag; valid only with `ready`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Acceptance: in IDLE or RESP, `req=1` latches Address, wr and Datain into internal registers. The latched values, not the live inputs, are used for the access.
- IDLE → RESP when accepted and WAIT=0. IDLE → WAIT when accepted and WAIT>0; the wait counter loads WAIT-1.
- WAIT: the counter decrements each cycle. At 0 → RESP. `req` is ignored in WAIT.
- RESP: `ready=1`. With `req=1`, accept the next transaction (back-to-back, same branch rules as IDLE); otherwise → IDLE.
- Write: the array is updated on the edge that enters RESP. Dataout is unchanged.
- Read: the array is read on the edge that enters RESP, and Dataout shows the word during RESP and afterwards.
- Read-after-write to the same word, back-to-back, returns the newly written data.
- Address wrap: upper address bits above the index are ignored, so addresses alias modulo DEPTH*4.
- Reset is asynchronous. It forces IDLE, counter=0, Dataout=0, ready=0, busy=0 and err=0, and aborts any held transaction with no array write. Array contents are not cleared.

## Timing
- Request accepted at edge N. `ready` is high in cycle N+1+WAIT, exactly one cycle.
- Sustained throughput is one transaction per WAIT+1 cycles.
- `busy` rises the cycle after acceptance and falls after RESP unless a new request is accepted in RESP.
- `Dataout` is registered. There is no combinational path from inputs to outputs.
- Reset values: Dataout=32'h0, ready=0, busy=0, err=0.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A latched Address with `[1:0]≠0` performs no array access.
  - Dataout is unchanged.
  - `err=1` together with `ready`, at the same latency.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `Address[1:0]` is ignored and the access uses the word index.
  - `err` is tied to 0.

## Structure
- Package `mem_pkg` holds:
  - the state enum `mem_state_t` {IDLE, WAIT, RESP};
  - `WORD_W=32`;
  - the wait-counter width constant `WAIT_CNT_W=4`.
- Sub-module `mem_array`: single-port synchronous RAM, DEPTH×32, write enable, registered read, no reset. It is instantiated once.
- `mem_responder` holds the FSM, the request latch, the wait counter, the alignment check and the Dataout register.

## Test plan
- Reset then idle: Dataout=0, ready=0 and busy=0 for 10 cycles with req=0.
- WAIT=2: write 32'hDEADBEEF to 0x10 at edge N, ready at cycle N+3. Then read 0x10, and Dataout=32'hDEADBEEF during ready.
- Back-to-back with WAIT=0: req held high, write 0x20 = 32'h12345678 then read 0x20. Ready pulses on consecutive cycles and the read returns 32'h12345678.
- Aliasing with DEPTH=256: write 32'hA5A5A5A5 to 0x004, read 0x404, and Dataout=32'hA5A5A5A5.
- Reset mid-transaction: assert Reset during WAIT of a write to 0x30 = 32'hFFFFFFFF. Outputs return to reset values immediately, no ready occurs, and a later read of 0x30 returns the prior contents.
- Misalignment, with `MEM_ALIGN_CHECK_EN` defined: read 0x13 gives ready with err=1 and Dataout unchanged. Without the macro, the same read gives err=0 and returns the word at 0x10.
